// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_flush,
  input  fetch_entry_t                   i_data,
  output fetch_entry_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wr_next;
  logic [PW-1:0] w_rd_next;

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    w_wr_next = (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + PW'(1);
    w_rd_next = (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= w_wr_next;
      if (i_pop)  r_rd <= w_rd_next;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests,
// buffers returned words and handles Execute redirects by dropping stale data.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic        ValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PcPlus4F
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH+1);

  logic [31:0]    r_fetch_pc;
  logic [31:0]    r_resp_pc;
  logic [CW-1:0]  r_inflight;
  logic [CW-1:0]  r_drop;
  logic           r_req_pending;

  logic [FCW-1:0] w_count;
  logic           w_empty;
  fetch_entry_t   w_head;
  fetch_entry_t   w_push_data;
  logic           w_pop;
  logic           w_push;
  logic           w_accept;
  logic           w_issue;
  logic [31:0]    w_target;
  int unsigned    w_occupancy;

  assign w_target = PCTargetE & ~32'h0000_0003;
  assign w_pop    = ValidF & ~StallF & ~PCSrcE;
  assign w_push   = ImemRValid & ~PCSrcE & (r_drop == '0);
  assign w_accept = ImemReq & ImemGnt;

  // Occupancy counts in-flight words so every response has a reserved slot.
  always_comb begin
    w_occupancy = 32'(r_inflight) + 32'(w_count) - 32'(w_pop);
    w_issue     = ~PCSrcE & (32'(r_inflight) < MAX_OUTSTANDING) &
                  (w_occupancy < FIFO_DEPTH);
  end

  // A raised but ungranted request stays up even if a stall removes the pop.
  assign ImemReq  = reset & ~PCSrcE & (r_req_pending | w_issue);
  assign ImemAddr = r_fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_inflight    <= '0;
      r_drop        <= '0;
      r_req_pending <= 1'b0;
    end else begin
      r_inflight    <= r_inflight + CW'(w_accept) - CW'(ImemRValid);
      r_req_pending <= ImemReq & ~ImemGnt;
      if (PCSrcE) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_drop     <= r_inflight - CW'(ImemRValid);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (ImemRValid) begin
          if (r_drop != '0) r_drop    <= r_drop - CW'(1);
          else              r_resp_pc <= r_resp_pc + PC_STEP;
        end
      end
    end
  end

  assign w_push_data = '{instr: ImemRData, pc: r_resp_pc};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (PCSrcE),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign ValidF   = ~w_empty;
  assign InstrF   = w_empty ? NOP_INSTR : w_head.instr;
  assign PCF      = w_empty ? r_resp_pc : w_head.pc;
  assign PcPlus4F = PCF + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, PCSrcE, ImemGnt, ImemRValid;
  logic [31:0] PCTargetE, ImemRData;
  logic        ImemReq, ValidF;
  logic [31:0] ImemAddr, InstrF, PCF, PcPlus4F;

  fetch_unit #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemGnt    (ImemGnt),
    .ImemRValid (ImemRValid),
    .ImemRData  (ImemRData),
    .ValidF     (ValidF),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .PcPlus4F   (PcPlus4F)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic [31:0] data; } mem_rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_rsp_t    memq[$];
  exp_t        expq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned lat      = 1;
  logic [31:0] tb_fetch;
  logic        hold_pend;
  logic        stall_v, redir_v, gnt_v;
  logic [31:0] tgt_v;
  logic        s_req, s_valid;
  logic [31:0] s_pcf;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, settle, compare, model the coming edge.
  task automatic step();
    logic rsp;
    StallF    = stall_v;
    PCSrcE    = redir_v;
    PCTargetE = tgt_v;
    ImemGnt   = gnt_v;
    rsp       = (memq.size() > 0) && (memq[0].due <= cyc);
    ImemRValid = rsp;
    ImemRData  = rsp ? memq[0].data : 32'hDEAD_BEEF;
    #1;
    s_req   = ImemReq;
    s_valid = ValidF;
    s_pcf   = PCF;
    if (hold_pend && !redir_v) begin
      check_eq("hold_req", {31'd0, ImemReq}, 32'd1);
      check_eq("hold_addr", ImemAddr, tb_fetch);
    end
    if (redir_v) check_eq("redir_noreq", {31'd0, ImemReq}, 32'd0);
    if (!ValidF) begin
      check_eq("idle_instr", InstrF, NOP);
    end else if (expq.size() == 0) begin
      check_eq("unexpected_valid", {31'd0, ValidF}, 32'd0);
    end else begin
      check_eq("pcf", PCF, expq[0].pc);
      check_eq("instr", InstrF, expq[0].instr);
      check_eq("pcplus4", PcPlus4F, expq[0].pc + 32'd4);
    end
    if (ImemReq && ImemGnt) begin
      check_eq("imem_addr", ImemAddr, tb_fetch);
      memq.push_back('{due: cyc + lat, data: mem_word(ImemAddr)});
      expq.push_back('{pc: tb_fetch, instr: mem_word(tb_fetch)});
      tb_fetch = tb_fetch + 32'd4;
    end
    if (rsp) void'(memq.pop_front());
    if (redir_v) begin
      expq.delete();
      tb_fetch = {tgt_v[31:2], 2'b00};
    end else if (ValidF && !StallF && expq.size() > 0) begin
      void'(expq.pop_front());
    end
    hold_pend = ImemReq && !ImemGnt;
    cyc++;
    @(negedge clk);
  endtask

  task automatic restart_and_measure();
    int unsigned first_valid;
    int unsigned n_valid;
    first_valid = 0;
    n_valid     = 0;
    for (int unsigned k = 1; k <= 12; k++) begin
      step();
      if (s_valid && first_valid == 0) first_valid = k;
      if (s_valid && k >= 3) n_valid++;
    end
    check_eq("first_valid_cycle", first_valid, 32'd3);
    check_eq("throughput", n_valid, 32'd10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    reset = 1'b0;
    stall_v = 1'b0; redir_v = 1'b0; gnt_v = 1'b1; tgt_v = '0;
    StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; ImemGnt = 1'b1;
    ImemRValid = 1'b0; ImemRData = '0;
    tb_fetch = RST_PC; hold_pend = 1'b0;
    s_req = 1'b0; s_valid = 1'b0; s_pcf = '0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_valid", {31'd0, ValidF}, 32'd0);
    check_eq("rst_instr", InstrF, NOP);
    check_eq("rst_pcf", PCF, RST_PC);
    check_eq("rst_pcplus4", PcPlus4F, RST_PC + 32'd4);
    check_eq("rst_req", {31'd0, ImemReq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Startup across the address wrap, then steady one-per-cycle flow.
    restart_and_measure();

    // Stall mid-stream: head frozen, requests stop once space is reserved.
    stall_v = 1'b1;
    repeat (5) step();
    check_eq("stall_req", {31'd0, s_req}, 32'd0);
    stall_v = 1'b0;
    repeat (4) step();

    // Grant withheld: request and address must hold.
    gnt_v = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      check_eq("gnt_low_req", {31'd0, s_req}, 32'd1);
    end
    gnt_v = 1'b1;
    repeat (4) step();

    // Redirect with two requests in flight.
    lat = 3;
    n = 0;
    while (memq.size() != 2 && n < 20) begin
      step();
      n++;
    end
    check_eq("two_inflight", memq.size(), 32'd2);
    redir_v = 1'b1;
    tgt_v   = 32'h0000_0103;
    step();
    redir_v = 1'b0;
    n = 0;
    s_valid = 1'b0;
    while (!s_valid && n < 30) begin
      step();
      n++;
    end
    check_eq("redir_seen", {31'd0, s_valid}, 32'd1);
    check_eq("redir_pc", s_pcf, 32'h0000_0100);
    lat = 1;
    repeat (8) step();

    // Fill the FIFO under stall, then reset asynchronously.
    stall_v = 1'b1;
    repeat (6) step();
    check_eq("full_req", {31'd0, s_req}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, ValidF}, 32'd0);
    check_eq("mid_rst_instr", InstrF, NOP);
    check_eq("mid_rst_req", {31'd0, ImemReq}, 32'd0);
    check_eq("mid_rst_pcf", PCF, RST_PC);
    memq.delete();
    expq.delete();
    tb_fetch  = RST_PC;
    hold_pend = 1'b0;
    stall_v   = 1'b0;
    StallF    = 1'b0;
    ImemRValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    restart_and_measure();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
